// File: rtl/ps2_key_decoder_if.sv
// Scancode-in / key-command-out bundle between the PS/2 receiver side and the key decoder.
// The decoder uses the slave modport; the byte source and game core use master.
interface ps2_key_decoder_if #(
    parameter int unsigned NUM_KEYS = 4
) ();
    logic [7:0]          data_in;
    logic                data_en;
    logic                move;
    logic [2:0]          dir;
    logic [NUM_KEYS-1:0] key_state;
    logic                evt_valid;
    logic                evt_make;
    logic [3:0]          evt_key;

    modport master (
        output data_in,
        output data_en,
        input  move,
        input  dir,
        input  key_state,
        input  evt_valid,
        input  evt_make,
        input  evt_key
    );

    modport slave (
        input  data_in,
        input  data_en,
        output move,
        output dir,
        output key_state,
        output evt_valid,
        output evt_make,
        output evt_key
    );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 scancode decoder: E0/F0 prefix FSM, held-key tracking, most-recent-key move/dir command.
// Optional prefix timeout enabled by defining PS2_KEYDEC_TIMEOUT_EN.
module ps2_key_decoder #(
    parameter int unsigned           NUM_KEYS       = 4,
    parameter logic [8*NUM_KEYS-1:0] KEY_CODES      = {8'h23, 8'h1B, 8'h1C, 8'h1D},
    parameter logic [NUM_KEYS-1:0]   KEY_EXT        = '0,
    parameter logic [3*NUM_KEYS-1:0] KEY_DIRS       = {3'b110, 3'b100, 3'b101, 3'b111},
    parameter int unsigned           PULSE_MODE     = 0,
    parameter int unsigned           REPEAT_CYCLES  = 12500000,
    parameter int unsigned           TIMEOUT_CYCLES = 2500000
) (
    input logic              clock,
    input logic              resetn,
    ps2_key_decoder_if.slave kbd_io
);

    if (NUM_KEYS < 1 || NUM_KEYS > 16 || REPEAT_CYCLES < 2 || TIMEOUT_CYCLES < 1)
    begin : g_param_check
        $error("ps2_key_decoder: parameter out of range");
    end

    localparam logic [7:0]  CodeE0    = 8'hE0;
    localparam logic [7:0]  CodeF0    = 8'hF0;
    localparam logic [31:0] RptReload = 32'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StGotE0, StGotF0, StGotE0F0} state_e;

    state_e              state_q, state_d;
    logic                code_ev, is_make, ext;
    logic                is_prefix;

    logic                hit;
    logic [3:0]          hit_idx;
    logic [NUM_KEYS-1:0] hit_oh;

    logic [NUM_KEYS-1:0] key_state_q, key_state_d;
    logic [NUM_KEYS-1:0] remain;
    logic                active_valid_q, active_valid_d;
    logic [3:0]          active_idx_q, active_idx_d;
    logic                act_change;
    logic                move_q, move_d;
    logic [2:0]          dir_q, dir_d;
    logic                evt_valid_q, evt_valid_d;
    logic                evt_make_q, evt_make_d;
    logic [3:0]          evt_key_q, evt_key_d;
    logic [31:0]         rpt_cnt_q, rpt_cnt_d;
    logic                pulse;

    assign is_prefix = (kbd_io.data_in == CodeE0) || (kbd_io.data_in == CodeF0);

`ifdef PS2_KEYDEC_TIMEOUT_EN
    logic [31:0] to_cnt_q, to_cnt_d;
    logic        to_hit;

    assign to_hit = (state_q != StIdle) && !kbd_io.data_en &&
                    (to_cnt_q == 32'(TIMEOUT_CYCLES - 1));

    always_comb begin
        to_cnt_d = to_cnt_q + 32'd1;
        if (state_q == StIdle || kbd_io.data_en || to_hit) begin
            to_cnt_d = '0;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`endif

    // Prefix FSM: state register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Prefix FSM: next state
    always_comb begin
        state_d = state_q;
        if (kbd_io.data_en) begin
            case (state_q)
                StIdle: begin
                    if (kbd_io.data_in == CodeE0)      state_d = StGotE0;
                    else if (kbd_io.data_in == CodeF0) state_d = StGotF0;
                end
                StGotE0: begin
                    if (kbd_io.data_in == CodeF0)      state_d = StGotE0F0;
                    else if (kbd_io.data_in != CodeE0) state_d = StIdle;
                end
                StGotF0: begin
                    if (kbd_io.data_in == CodeE0)      state_d = StGotE0F0;
                    else if (kbd_io.data_in != CodeF0) state_d = StIdle;
                end
                StGotE0F0: begin
                    if (!is_prefix) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
`ifdef PS2_KEYDEC_TIMEOUT_EN
        else if (to_hit) begin
            state_d = StIdle;
        end
`endif
    end

    // Prefix FSM: decoded make/break event for a non-prefix byte
    always_comb begin
        code_ev = 1'b0;
        is_make = 1'b0;
        ext     = 1'b0;
        if (kbd_io.data_en && !is_prefix) begin
            code_ev = 1'b1;
            case (state_q)
                StIdle:    is_make = 1'b1;
                StGotE0:   begin is_make = 1'b1; ext = 1'b1; end
                StGotF0:   is_make = 1'b0;
                StGotE0F0: ext = 1'b1;
                default:   is_make = 1'b1;
            endcase
        end
    end

    // Descending scan so the lowest matching index is the one left standing
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        hit_oh  = '0;
        for (int i = int'(NUM_KEYS) - 1; i >= 0; i--) begin
            if (KEY_CODES[8*i +: 8] == kbd_io.data_in && KEY_EXT[i] == ext) begin
                hit       = 1'b1;
                hit_idx   = 4'(i);
                hit_oh    = '0;
                hit_oh[i] = 1'b1;
            end
        end
    end

    assign remain = key_state_q & ~hit_oh;

    always_comb begin
        key_state_d    = key_state_q;
        active_valid_d = active_valid_q;
        active_idx_d   = active_idx_q;
        evt_valid_d    = 1'b0;
        evt_make_d     = evt_make_q;
        evt_key_d      = evt_key_q;
        act_change     = 1'b0;
        if (code_ev && hit) begin
            if (is_make && ((key_state_q & hit_oh) == '0)) begin
                key_state_d    = key_state_q | hit_oh;
                active_valid_d = 1'b1;
                active_idx_d   = hit_idx;
                evt_valid_d    = 1'b1;
                evt_make_d     = 1'b1;
                evt_key_d      = hit_idx;
                act_change     = 1'b1;
            end else if (!is_make && ((key_state_q & hit_oh) != '0)) begin
                key_state_d = remain;
                evt_valid_d = 1'b1;
                evt_make_d  = 1'b0;
                evt_key_d   = hit_idx;
                if (active_valid_q && active_idx_q == hit_idx) begin
                    active_valid_d = 1'b0;
                    active_idx_d   = '0;
                    for (int i = int'(NUM_KEYS) - 1; i >= 0; i--) begin
                        if (remain[i]) begin
                            active_valid_d = 1'b1;
                            active_idx_d   = 4'(i);
                        end
                    end
                    act_change = active_valid_d;
                end
            end
        end
    end

    // Auto-repeat: a fresh activation wins over a same-cycle expiry, both reload
    always_comb begin
        pulse     = 1'b0;
        rpt_cnt_d = '0;
        if (active_valid_d) begin
            if (act_change || rpt_cnt_q == '0) begin
                pulse     = 1'b1;
                rpt_cnt_d = RptReload;
            end else begin
                rpt_cnt_d = rpt_cnt_q - 32'd1;
            end
        end
    end

    always_comb begin
        move_d = (PULSE_MODE != 0) ? pulse : active_valid_d;
        dir_d  = active_valid_d ? KEY_DIRS[3*int'(active_idx_d) +: 3] : 3'b000;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            key_state_q    <= '0;
            active_valid_q <= 1'b0;
            active_idx_q   <= '0;
            move_q         <= 1'b0;
            dir_q          <= 3'b000;
            evt_valid_q    <= 1'b0;
            evt_make_q     <= 1'b0;
            evt_key_q      <= '0;
            rpt_cnt_q      <= '0;
        end else begin
            key_state_q    <= key_state_d;
            active_valid_q <= active_valid_d;
            active_idx_q   <= active_idx_d;
            move_q         <= move_d;
            dir_q          <= dir_d;
            evt_valid_q    <= evt_valid_d;
            evt_make_q     <= evt_make_d;
            evt_key_q      <= evt_key_d;
            rpt_cnt_q      <= rpt_cnt_d;
        end
    end

    assign kbd_io.move      = move_q;
    assign kbd_io.dir       = dir_q;
    assign kbd_io.key_state = key_state_q;
    assign kbd_io.evt_valid = evt_valid_q;
    assign kbd_io.evt_make  = evt_make_q;
    assign kbd_io.evt_key   = evt_key_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: default, E0-mapped and pulse-mode instances share one byte stream.
module tb_ps2_key_decoder;

    logic clock;
    logic resetn;
    int   total;
    int   bad;
    int   pcnt;

    ps2_key_decoder_if #(.NUM_KEYS(4)) if_def ();
    ps2_key_decoder_if #(.NUM_KEYS(4)) if_ext ();
    ps2_key_decoder_if #(.NUM_KEYS(4)) if_pul ();

    ps2_key_decoder #(
        .NUM_KEYS(4),
        .TIMEOUT_CYCLES(20)
    ) u_def (
        .clock (clock),
        .resetn(resetn),
        .kbd_io(if_def)
    );

    ps2_key_decoder #(
        .NUM_KEYS(4),
        .KEY_EXT(4'b0001)
    ) u_ext (
        .clock (clock),
        .resetn(resetn),
        .kbd_io(if_ext)
    );

    ps2_key_decoder #(
        .NUM_KEYS(4),
        .PULSE_MODE(1),
        .REPEAT_CYCLES(10)
    ) u_pul (
        .clock (clock),
        .resetn(resetn),
        .kbd_io(if_pul)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [7:0] b, input logic en);
        if_def.data_in = b; if_def.data_en = en;
        if_ext.data_in = b; if_ext.data_en = en;
        if_pul.data_in = b; if_pul.data_en = en;
    endtask

    // Returns one cycle after the strobe was sampled, when its effect is visible
    task automatic send(input logic [7:0] b);
        @(posedge clock); #1;
        drive(b, 1'b1);
        @(posedge clock); #1;
        drive(8'h00, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clock); #1;
        resetn = 1'b0;
        idle(2);
        resetn = 1'b1;
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        resetn = 1'b0;
        drive(8'h00, 1'b0);
        idle(3);
        chk("rst_move", 32'(if_def.move), 0);
        chk("rst_dir", 32'(if_def.dir), 0);
        chk("rst_keys", 32'(if_def.key_state), 0);
        chk("rst_evt", 32'(if_def.evt_valid), 0);
        chk("rst_pul_move", 32'(if_pul.move), 0);
        resetn = 1'b1;

        // Single press/release
        send(8'h1D);
        chk("p_move", 32'(if_def.move), 1);
        chk("p_dir", 32'(if_def.dir), 32'h7);
        chk("p_keys", 32'(if_def.key_state), 32'h1);
        chk("p_evt", 32'(if_def.evt_valid), 1);
        chk("p_make", 32'(if_def.evt_make), 1);
        chk("p_key", 32'(if_def.evt_key), 0);
        chk("ext_noe0_keys", 32'(if_ext.key_state), 0);
        chk("ext_noe0_evt", 32'(if_ext.evt_valid), 0);
        idle(1);
        chk("p_evt_1cyc", 32'(if_def.evt_valid), 0);
        send(8'hF0);
        chk("f0_pending_keys", 32'(if_def.key_state), 32'h1);
        send(8'h1D);
        chk("r_move", 32'(if_def.move), 0);
        chk("r_dir", 32'(if_def.dir), 0);
        chk("r_keys", 32'(if_def.key_state), 0);
        chk("r_evt", 32'(if_def.evt_valid), 1);
        chk("r_make", 32'(if_def.evt_make), 0);

        // Overlap: newest wins, releasing it falls back to the older key
        send(8'h1D);
        send(8'h1C);
        chk("ov_dir", 32'(if_def.dir), 32'h5);
        chk("ov_keys", 32'(if_def.key_state), 32'h3);
        chk("ov_evtkey", 32'(if_def.evt_key), 1);
        send(8'hF0); send(8'h1C);
        chk("ov_back_dir", 32'(if_def.dir), 32'h7);
        chk("ov_back_keys", 32'(if_def.key_state), 32'h1);
        chk("ov_back_move", 32'(if_def.move), 1);
        send(8'hF0); send(8'h1D);
        chk("ov_end_move", 32'(if_def.move), 0);

        // Releasing a non-active key leaves the active one alone
        send(8'h1D); send(8'h1C);
        send(8'hF0); send(8'h1D);
        chk("na_dir", 32'(if_def.dir), 32'h5);
        chk("na_keys", 32'(if_def.key_state), 32'h2);
        send(8'hF0); send(8'h1C);
        chk("na_end_move", 32'(if_def.move), 0);
        chk("na_end_dir", 32'(if_def.dir), 0);

        // E0-mapped key
        send(8'h1D);
        chk("ext_plain_keys", 32'(if_ext.key_state), 0);
        send(8'hE0); send(8'h1D);
        chk("ext_make_keys", 32'(if_ext.key_state), 32'h1);
        chk("ext_make_evt", 32'(if_ext.evt_valid), 1);
        chk("def_e0_keys", 32'(if_def.key_state), 32'h1);
        chk("def_e0_evt", 32'(if_def.evt_valid), 0);
        send(8'hE0); send(8'hF0);
        chk("ext_pending_keys", 32'(if_ext.key_state), 32'h1);
        send(8'h1D);
        chk("ext_brk_keys", 32'(if_ext.key_state), 0);
        chk("ext_brk_make", 32'(if_ext.evt_make), 0);
        send(8'hF0); send(8'h1D);
        chk("def_clear_keys", 32'(if_def.key_state), 0);

        // Unmapped byte and typematic repeats
        send(8'h5A);
        chk("unm_keys", 32'(if_def.key_state), 0);
        chk("unm_evt", 32'(if_def.evt_valid), 0);
        send(8'h1D);
        chk("tm_first_evt", 32'(if_def.evt_valid), 1);
        send(8'h1D);
        chk("tm_rep_evt", 32'(if_def.evt_valid), 0);
        chk("tm_rep_keys", 32'(if_def.key_state), 32'h1);
        send(8'h1C);
        send(8'h1D);
        chk("tm_active_dir", 32'(if_def.dir), 32'h5);
        chk("tm_active_evt", 32'(if_def.evt_valid), 0);
        send(8'hF0); send(8'h1C);
        send(8'hF0); send(8'h1D);
        chk("tm_end_keys", 32'(if_def.key_state), 0);

        // Pulse mode with auto-repeat
        do_reset();
        send(8'h1D);
        pcnt = 0;
        for (int i = 0; i < 35; i++) begin
            if (if_pul.move) pcnt++;
            if (i == 0)  chk("pul_first", 32'(if_pul.move), 1);
            if (i == 1)  chk("pul_gap", 32'(if_pul.move), 0);
            if (i == 9)  chk("pul_before_rep", 32'(if_pul.move), 0);
            if (i == 10) chk("pul_rep", 32'(if_pul.move), 1);
            @(posedge clock); #1;
        end
        chk("pul_count", 32'(pcnt), 4);
        send(8'hF0); send(8'h1D);
        pcnt = 0;
        for (int i = 0; i < 25; i++) begin
            if (if_pul.move) pcnt++;
            @(posedge clock); #1;
        end
        chk("pul_released", 32'(pcnt), 0);

        // Asynchronous reset while a key is held
        send(8'h1D);
        chk("ar_pre_move", 32'(if_def.move), 1);
        #2;
        resetn = 1'b0;
        #1;
        chk("ar_move", 32'(if_def.move), 0);
        chk("ar_keys", 32'(if_def.key_state), 0);
        chk("ar_dir", 32'(if_def.dir), 0);
        @(posedge clock); #1;
        resetn = 1'b1;

        // Stale F0 prefix: dropped only when the timeout is built in
        send(8'hF0);
        idle(25);
        send(8'h1D);
`ifdef PS2_KEYDEC_TIMEOUT_EN
        chk("to_make_move", 32'(if_def.move), 1);
`else
        chk("to_break_move", 32'(if_def.move), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
